// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - lane-count and lane-index-width helpers shared by the AXI-Stream width converters
//
// Purpose: compile-time width helper and a popcount used to turn a tkeep
// mask into a lane count. Shared between axis_downsizer and axis_upsizer.
// Ports: none (package).

package axis_pkg;

    // Widest tkeep the popcount helper accepts; callers zero-extend into it.
    localparam int MAX_LANES = 64;

    // Bits needed to index 0..ratio-1; never less than one bit.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Number of set bits in a keep mask. Holes in the mask are counted too,
    // so a non-contiguous mask still yields its popcount.
    function automatic int lane_count(input logic [MAX_LANES-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n += int'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_downsizer.sv
// rtl/axis_downsizer.sv - AXI-Stream width downsizer, one wide beat out as DATA_RATIO narrow lanes
//
// Purpose: captures one wide beat into a holding register and replays it
// lane by lane (lane 0 first), honouring tkeep so only the valid lanes are
// emitted. The final-lane handshake reopens the slave side in the same
// cycle so full beats stream without a bubble.
// Ports:
//   aclk, areset                      clock, synchronous active-high reset
//   s_axis_tdata/tkeep/tvalid/tlast   wide slave stream in
//   s_axis_tready                     slave ready out
//   m_axis_tdata/tvalid/tlast         narrow master stream out
//   m_axis_tready                     master ready in
//   err_null_beat                     sticky: a beat with tkeep==0 was accepted

module axis_downsizer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DATA_RATIO   = 8,
    parameter int S_DATA_WIDTH = DATA_RATIO * DATA_WIDTH,
    parameter int M_DATA_WIDTH = DATA_WIDTH
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [DATA_RATIO-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    err_null_beat
);

    localparam int IDX_W = idx_width(DATA_RATIO);
    // One extra bit so a full beat (N == DATA_RATIO) does not wrap to zero.
    localparam int CNT_W = IDX_W + 1;

    logic [S_DATA_WIDTH-1:0] r_data;
    logic                    r_busy;
    logic                    r_last;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;

    logic [CNT_W-1:0]        w_keep_cnt;
    logic                    w_out_hs;
    logic                    w_final_lane;
    logic                    w_beat_end;
    logic                    w_in_hs;
    logic                    w_null;
    logic                    w_load;
    logic [DATA_WIDTH-1:0]   w_lanes [DATA_RATIO];

    assign w_keep_cnt   = CNT_W'(lane_count(MAX_LANES'(s_axis_tkeep)));

    assign w_out_hs     = r_busy && m_axis_tready;
    assign w_final_lane = ({1'b0, r_idx} == (r_cnt - CNT_W'(1)));
    assign w_beat_end   = w_out_hs && w_final_lane;

    // Ready reopens on the last lane's handshake, giving back-to-back beats.
    assign s_axis_tready = (!r_busy || w_beat_end) && !areset;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_null        = w_in_hs && (w_keep_cnt == '0);
    assign w_load        = w_in_hs && !w_null;

    for (genvar g = 0; g < DATA_RATIO; g++) begin : g_lane
        assign w_lanes[g] = r_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign m_axis_tdata  = w_lanes[r_idx];
    assign m_axis_tvalid = r_busy;
    assign m_axis_tlast  = r_busy && r_last && w_final_lane;
    assign err_null_beat = r_err;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_busy <= 1'b0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_null) begin
                r_err <= 1'b1;
            end
            // A null beat is dropped outright; it neither loads nor holds
            // off the end of the beat currently draining.
            if (w_load) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
                r_cnt  <= w_keep_cnt;
                r_last <= s_axis_tlast;
            end else if (w_beat_end) begin
                r_busy <= 1'b0;
                r_idx  <= '0;
            end else if (w_out_hs) begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    // Holding data is qualified by r_busy, so it needs no reset.
    always_ff @(posedge aclk) begin
        if (w_load) begin
            r_data <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_axis_downsizer.sv
// tb/tb_axis_downsizer.sv - self-checking bench for axis_downsizer (8-bit lanes, ratio 4)

module tb_axis_downsizer;

    localparam int DW = 8;
    localparam int R  = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b0;
    logic        err_null_beat;

    always #5 aclk = ~aclk;

    axis_downsizer #(.DATA_WIDTH(DW), .DATA_RATIO(R)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .err_null_beat (err_null_beat)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the lanes still owed to the master side, {last, data}.
    logic [8:0] q[$];
    logic       m_err = 1'b0;

    logic       smp_sr, smp_mv, smp_ml, smp_err;
    logic [7:0] smp_md;

    typedef struct {
        logic        rst, sv;
        logic [31:0] sd;
        logic [3:0]  sk;
        logic        sl, mr, mv;
        logic [7:0]  md;
        logic        ml, sr, er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, sv, input logic [31:0] sd,
                                input logic [3:0] sk, input logic sl, mr, mv,
                                input logic [7:0] md, input logic ml, sr, er);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sd = sd; v.sk = sk; v.sl = sl; v.mr = mr;
        v.mv = mv; v.md = md; v.ml = ml; v.sr = sr; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample and check against the model,
    // advance the model, then move to just after the next rising edge.
    task automatic cycle(input logic rst, sv, input logic [31:0] sd,
                         input logic [3:0] sk, input logic sl, mr);
        logic e_sr, e_mv;
        int   n;
        areset = rst; s_tvalid = sv; s_tdata = sd; s_tkeep = sk;
        s_tlast = sl; m_tready = mr;
        #1;
        smp_sr = s_tready; smp_mv = m_tvalid; smp_ml = m_tlast;
        smp_md = m_tdata;  smp_err = err_null_beat;
        e_mv = (q.size() != 0);
        e_sr = !rst && ((q.size() == 0) || (q.size() == 1 && mr));
        chk("model_m_valid", 32'(smp_mv), 32'(e_mv));
        chk("model_s_ready", 32'(smp_sr), 32'(e_sr));
        chk("model_err", 32'(smp_err), 32'(m_err));
        if (e_mv) begin
            chk("model_m_data", 32'(smp_md), 32'(q[0][7:0]));
            chk("model_m_last", 32'(smp_ml), 32'(q[0][8]));
        end else begin
            chk("model_m_last_idle", 32'(smp_ml), 32'(1'b0));
        end
        if (rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (e_mv && mr) void'(q.pop_front());
            if (sv && e_sr) begin
                n = $countones(sk);
                if (n == 0) m_err = 1'b1;
                else for (int i = 0; i < n; i++)
                    q.push_back({(sl && i == n - 1), sd[i*8 +: 8]});
            end
        end
        @(posedge aclk);
        #1;
    endtask

    logic [31:0] beats [4];
    logic        mrp [6];
    logic [7:0]  got_lanes[$];

    initial begin
        // rst sv  sd            sk    sl  mr  | mv  md     ml  sr  er
        tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h44332211, 4'hF, 1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h22, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h33, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h44, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h00CCBBAA, 4'h7, 1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'hAA, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'hBB, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'hCC, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h12345678, 4'h0, 1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 1, 1));
        tbl.push_back(mk(1, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h0000BBAA, 4'h3, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h0000DDCC, 4'h3, 1, 1, 1, 8'hAA, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0000DDCC, 4'h3, 1, 1, 1, 8'hBB, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'hCC, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'hDD, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h000000EE, 4'h1, 1, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 8'hEE, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 1, 0));

        repeat (3) @(posedge aclk);
        #1;

        foreach (tbl[k]) begin
            cycle(tbl[k].rst, tbl[k].sv, tbl[k].sd, tbl[k].sk, tbl[k].sl, tbl[k].mr);
            chk($sformatf("vec%0d_m_valid", k), 32'(smp_mv), 32'(tbl[k].mv));
            chk($sformatf("vec%0d_s_ready", k), 32'(smp_sr), 32'(tbl[k].sr));
            chk($sformatf("vec%0d_err", k), 32'(smp_err), 32'(tbl[k].er));
            if (tbl[k].mv) begin
                chk($sformatf("vec%0d_m_data", k), 32'(smp_md), 32'(tbl[k].md));
                chk($sformatf("vec%0d_m_last", k), 32'(smp_ml), 32'(tbl[k].ml));
            end
        end

        // Three full beats offered continuously: accepted every 4 cycles,
        // twelve output lanes with no gap.
        begin
            int b = 0, nvalid = 0, first_v = -1, last_v = -1;
            int acc[$];
            beats[0] = 32'h03020100; beats[1] = 32'h07060504;
            beats[2] = 32'h0B0A0908; beats[3] = 32'h0;
            for (int c = 0; c < 16; c++) begin
                cycle(1'b0, b < 3, beats[b], 4'hF, b == 2, 1'b1);
                if (smp_mv) begin
                    nvalid++;
                    if (first_v < 0) first_v = c;
                    last_v = c;
                end
                if (b < 3 && smp_sr) begin
                    acc.push_back(c);
                    b++;
                end
            end
            chk("b2b_accept_count", 32'(acc.size()), 32'd3);
            chk("b2b_accept_gap1", 32'(acc[1] - acc[0]), 32'd4);
            chk("b2b_accept_gap2", 32'(acc[2] - acc[1]), 32'd4);
            chk("b2b_valid_count", 32'(nvalid), 32'd12);
            chk("b2b_valid_span", 32'(last_v - first_v + 1), 32'd12);
        end

        // Master stalls mid-beat: no lane lost or repeated, data held.
        mrp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        got_lanes.delete();
        cycle(1'b0, 1'b1, 32'h0D0C0B0A, 4'hF, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, mrp[c]);
            if (!mrp[c]) chk("stall_data_hold", 32'(smp_md), 32'h0B);
            if (smp_mv && mrp[c]) got_lanes.push_back(smp_md);
        end
        chk("stall_lane_count", 32'(got_lanes.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stall_lane%0d", i), 32'(got_lanes[i]), 32'(8'h0A + i));

        // Reset after two of four lanes: remaining lanes dropped.
        cycle(1'b0, 1'b1, 32'h88776655, 4'hF, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'hDDCCBBAA, 4'hF, 1'b1, 1'b1);
        chk("rst_mid_m_valid", 32'(smp_mv), 32'd0);
        chk("rst_mid_s_ready", 32'(smp_sr), 32'd1);
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("rst_mid_first_lane", 32'(smp_md), 32'hAA);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic rst, sv, sl, mr;
            int   k;
            rst = ($urandom_range(0, 299) == 0);
            sv  = ($urandom_range(0, 2) != 0);
            sl  = $urandom_range(0, 1) != 0;
            mr  = ($urandom_range(0, 3) != 0);
            k   = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
            cycle(rst, sv, $urandom, 4'((1 << k) - 1), sl, mr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
